// File: rtl/branch_resolver.sv
// Branch/jump resolution stage: evaluates branch conditions from ALU flags, computes redirect
// targets and keeps saturating branch statistics behind a single registered valid/ready stage.
module branch_resolver #(
    parameter int WORDSIZE      = 64,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [2:0]               in_funct3,
    input  logic [WORDSIZE-1:0]      in_pc,
    input  logic [WORDSIZE-1:0]      in_imm,
    input  logic [WORDSIZE-1:0]      in_rs1,
    input  logic                     flag_equal,
    input  logic                     flag_not_equal,
    input  logic                     flag_less,
    input  logic                     flag_u_less,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_taken,
    output logic [WORDSIZE-1:0]      out_target,
    output logic [WORDSIZE-1:0]      out_next_pc,
    output logic                     out_illegal,
    output logic                     out_misaligned,
    output logic [COUNTER_WIDTH-1:0] count_branches,
    output logic [COUNTER_WIDTH-1:0] count_taken
);

    typedef enum logic [1:0] {
        OP_BRANCH = 2'b00,
        OP_JAL    = 2'b01,
        OP_JALR   = 2'b10,
        OP_OTHER  = 2'b11
    } op_e;

    logic                accept;
    logic                cond;
    logic                illegal;
    logic                misaligned;
    logic                taken;
    logic [WORDSIZE-1:0] next_pc;
    logic [WORDSIZE-1:0] target;
    logic [WORDSIZE-1:0] jalr_sum;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign next_pc  = in_pc + WORDSIZE'(4);
    assign jalr_sum = in_rs1 + in_imm;

    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        target  = in_pc + in_imm;
        case (op_e'(in_op))
            OP_BRANCH: begin
                case (in_funct3)
                    3'b000:  cond = flag_equal;
                    3'b001:  cond = flag_not_equal;
                    3'b100:  cond = flag_less;
                    3'b101:  cond = !flag_less;
                    3'b110:  cond = flag_u_less;
                    3'b111:  cond = !flag_u_less;
                    default: illegal = 1'b1;
                endcase
            end
            OP_JAL: cond = 1'b1;
            OP_JALR: begin
                cond   = 1'b1;
                target = jalr_sum & ~WORDSIZE'(1);
            end
            default: target = next_pc;
        endcase
    end

    // A taken redirect to a non-word-aligned target is reported instead of followed.
    assign misaligned = cond && (target[1:0] != 2'b00);
    assign taken      = cond && !misaligned;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_taken      <= 1'b0;
            out_target     <= '0;
            out_next_pc    <= '0;
            out_illegal    <= 1'b0;
            out_misaligned <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_taken      <= taken;
            out_target     <= target;
            out_next_pc    <= next_pc;
            out_illegal    <= illegal;
            out_misaligned <= misaligned;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Statistics saturate at all-ones so a long run never reads back as a small count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_branches <= '0;
            count_taken    <= '0;
        end else if (accept) begin
            if ((op_e'(in_op) != OP_OTHER) && (count_branches != '1))
                count_branches <= count_branches + COUNTER_WIDTH'(1);
            if (taken && (count_taken != '1))
                count_taken <= count_taken + COUNTER_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: directed vectors push hand-computed results into a
// queue; a monitor pops and compares whenever the DUT hands a result downstream.
module tb_branch_resolver;

    localparam int W  = 64;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_op = 2'b11;
    logic [2:0]    in_funct3 = 3'b000;
    logic [W-1:0]  in_pc = '0;
    logic [W-1:0]  in_imm = '0;
    logic [W-1:0]  in_rs1 = '0;
    logic          flag_equal = 1'b0;
    logic          flag_not_equal = 1'b0;
    logic          flag_less = 1'b0;
    logic          flag_u_less = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_taken;
    logic [W-1:0]  out_target;
    logic [W-1:0]  out_next_pc;
    logic          out_illegal;
    logic          out_misaligned;
    logic [CW-1:0] count_branches;
    logic [CW-1:0] count_taken;

    branch_resolver #(.WORDSIZE(W), .COUNTER_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_funct3(in_funct3), .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1),
        .flag_equal(flag_equal), .flag_not_equal(flag_not_equal),
        .flag_less(flag_less), .flag_u_less(flag_u_less),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_target(out_target), .out_next_pc(out_next_pc),
        .out_illegal(out_illegal), .out_misaligned(out_misaligned),
        .count_branches(count_branches), .count_taken(count_taken)
    );

    always #5 clk = ~clk;

    // flags packed as {equal, not_equal, less, u_less}
    typedef struct {
        logic [1:0]   op;
        logic [2:0]   f3;
        logic [W-1:0] pc;
        logic [W-1:0] imm;
        logic [W-1:0] rs1;
        logic [3:0]   flags;
        logic         taken;
        logic [W-1:0] target;
        logic [W-1:0] next_pc;
        logic         illegal;
        logic         mis;
    } vec_t;

    vec_t expq[$];
    int   num_vectors = 0;
    int   miscompares = 0;
    int   exp_branches = 0;
    int   exp_taken = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        num_vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [2:0] f3, input logic [W-1:0] pc,
                                input logic [W-1:0] imm, input logic [W-1:0] rs1, input logic [3:0] flags,
                                input logic taken, input logic [W-1:0] target, input logic [W-1:0] next_pc,
                                input logic illegal, input logic mis);
        vec_t v;
        v.op = op; v.f3 = f3; v.pc = pc; v.imm = imm; v.rs1 = rs1; v.flags = flags;
        v.taken = taken; v.target = target; v.next_pc = next_pc; v.illegal = illegal; v.mis = mis;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_op = v.op; in_funct3 = v.f3; in_pc = v.pc; in_imm = v.imm; in_rs1 = v.rs1;
        {flag_equal, flag_not_equal, flag_less, flag_u_less} = v.flags;
        in_valid = 1'b1;
    endtask

    task automatic record(input vec_t v);
        expq.push_back(v);
        if (v.op != 2'b11 && exp_branches < 15) exp_branches++;
        if (v.taken && exp_taken < 15) exp_taken++;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic applyStimulus(input vec_t v);
        bit accepted = 0;
        drive(v);
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) begin
                record(v);
                accepted = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!accepted) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        bit empty = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && !empty; i++) begin
            @(negedge clk);
            if (!out_valid) empty = 1;
            @(posedge clk); #1;
        end
        if (!empty) check("drain_timeout", 0, 1);
    endtask

    task automatic checkCounters(input string tag);
        check({tag, "_count_branches"}, W'(count_branches), W'(exp_branches));
        check({tag, "_count_taken"}, W'(count_taken), W'(exp_taken));
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                vec_t e;
                e = expq.pop_front();
                check("taken", W'(out_taken), W'(e.taken));
                check("target", out_target, e.target);
                check("next_pc", out_next_pc, e.next_pc);
                check("illegal", W'(out_illegal), W'(e.illegal));
                check("misaligned", W'(out_misaligned), W'(e.mis));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[$];
        vec_t a;
        vec_t b;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_out_valid", W'(out_valid), 0);
        check("reset_in_ready", W'(in_ready), 1);
        check("reset_out_taken", W'(out_taken), 0);
        check("reset_out_target", out_target, 0);
        check("reset_count_branches", W'(count_branches), 0);
        check("reset_count_taken", W'(count_taken), 0);
        @(posedge clk); #1;

        // BEQ taken, then counter check after one accept
        applyStimulus(mk(2'b00, 3'b000, 64'h1000, 64'h20, 64'h0, 4'b1000, 1, 64'h1020, 64'h1004, 0, 0));
        @(negedge clk);
        check("first_count_taken", W'(count_taken), 1);
        check("first_count_branches", W'(count_branches), 1);
        @(posedge clk); #1;

        vecs.push_back(mk(2'b00, 3'b111, 64'h2000, 64'h40, 64'h0, 4'b0101, 0, 64'h2040, 64'h2004, 0, 0));
        vecs.push_back(mk(2'b00, 3'b100, 64'h100, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 4'b0110, 1, 64'hF8, 64'h104, 0, 0));
        vecs.push_back(mk(2'b00, 3'b101, 64'h200, 64'h10, 64'h0, 4'b0100, 1, 64'h210, 64'h204, 0, 0));
        vecs.push_back(mk(2'b00, 3'b001, 64'h300, 64'h40, 64'h0, 4'b1000, 0, 64'h340, 64'h304, 0, 0));
        vecs.push_back(mk(2'b00, 3'b110, 64'h400, 64'h0C, 64'h0, 4'b0101, 1, 64'h40C, 64'h404, 0, 0));
        vecs.push_back(mk(2'b10, 3'b000, 64'h3000, 64'h3, 64'h2001, 4'b0000, 1, 64'h2004, 64'h3004, 0, 0));
        vecs.push_back(mk(2'b10, 3'b000, 64'h3000, 64'h2, 64'h2001, 4'b0000, 0, 64'h2002, 64'h3004, 0, 1));
        vecs.push_back(mk(2'b01, 3'b000, 64'h4000, 64'h100, 64'h0, 4'b0000, 1, 64'h4100, 64'h4004, 0, 0));
        vecs.push_back(mk(2'b11, 3'b000, 64'h5000, 64'h123, 64'h0, 4'b1111, 0, 64'h5004, 64'h5004, 0, 0));
        vecs.push_back(mk(2'b00, 3'b010, 64'h6000, 64'h8, 64'h0, 4'b1000, 0, 64'h6008, 64'h6004, 1, 0));
        vecs.push_back(mk(2'b00, 3'b011, 64'h6100, 64'h8, 64'h0, 4'b1000, 0, 64'h6108, 64'h6104, 1, 0));
        vecs.push_back(mk(2'b00, 3'b000, 64'h1000, 64'h2, 64'h0, 4'b1000, 0, 64'h1002, 64'h1004, 0, 1));
        vecs.push_back(mk(2'b01, 3'b000, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'h0, 4'b0000, 1, 64'h10, 64'hFFFF_FFFF_FFFF_FFF4, 0, 0));
        vecs.push_back(mk(2'b00, 3'b100, 64'h700, 64'h8, 64'h0, 4'b0001, 0, 64'h708, 64'h704, 0, 0));
        foreach (vecs[i]) applyStimulus(vecs[i]);
        drain();
        checkCounters("main");

        // Backpressure: held result stays put and in_ready drops until out_ready returns
        out_ready = 1'b0;
        a = mk(2'b01, 3'b000, 64'h8000, 64'h40, 64'h0, 4'b0000, 1, 64'h8040, 64'h8004, 0, 0);
        b = mk(2'b11, 3'b000, 64'h9000, 64'h0, 64'h0, 4'b0000, 0, 64'h9004, 64'h9004, 0, 0);
        applyStimulus(a);
        drive(b);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", W'(in_ready), 0);
            check("bp_out_valid", W'(out_valid), 1);
            check("bp_target_stable", out_target, 64'h8040);
            check("bp_next_pc_stable", out_next_pc, 64'h8004);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", W'(in_ready), 1);
        if (in_ready) record(b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Flush kills a held result; a flush-cycle input is not accepted or counted
        out_ready = 1'b0;
        applyStimulus(mk(2'b11, 3'b000, 64'hA000, 64'h0, 64'h0, 4'b0000, 0, 64'hA004, 64'hA004, 0, 0));
        drive(mk(2'b01, 3'b000, 64'hB000, 64'h8, 64'h0, 4'b0000, 1, 64'hB008, 64'hB004, 0, 0));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        void'(expq.pop_back());
        @(negedge clk);
        check("flush_held_out_valid", W'(out_valid), 0);
        checkCounters("flush_held");
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(mk(2'b01, 3'b000, 64'hB000, 64'h8, 64'h0, 4'b0000, 1, 64'hB008, 64'hB004, 0, 0));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_empty_out_valid", W'(out_valid), 0);
        checkCounters("flush_empty");
        @(posedge clk); #1;

        // Saturation with a 4-bit counter
        for (int i = 0; i < 20; i++)
            applyStimulus(mk(2'b01, 3'b000, 64'hC000, 64'h10, 64'h0, 4'b0000, 1, 64'hC010, 64'hC004, 0, 0));
        drain();
        check("sat_count_taken", W'(count_taken), 15);
        check("sat_count_branches", W'(count_branches), 15);

        // Asynchronous reset while a result is held
        out_ready = 1'b0;
        applyStimulus(mk(2'b01, 3'b000, 64'hD000, 64'h10, 64'h0, 4'b0000, 1, 64'hD010, 64'hD004, 0, 0));
        #2 reset = 1'b1;
        #1;
        check("async_out_valid", W'(out_valid), 0);
        check("async_out_taken", W'(out_taken), 0);
        check("async_out_target", out_target, 0);
        check("async_out_next_pc", out_next_pc, 0);
        check("async_count_taken", W'(count_taken), 0);
        check("async_count_branches", W'(count_branches), 0);
        expq.delete();
        exp_branches = 0;
        exp_taken = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", W'(in_ready), 1);
        @(posedge clk); #1;
        applyStimulus(mk(2'b00, 3'b000, 64'h1000, 64'h20, 64'h0, 4'b1000, 1, 64'h1020, 64'h1004, 0, 0));
        drain();
        checkCounters("post_reset");
        check("queue_empty", W'(expq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", num_vectors, miscompares);
        $finish;
    end

endmodule
